// File: rtl/key_lock_table_pkg.sv
// Shared types and defaults for the key lock table and its testbench.
package lock_pkg;

  localparam int KEY_W = 32;
  localparam logic [KEY_W-1:0] INVALID_KEY_DEFAULT = 32'hFFFF_FFFF;
  localparam int MAX_LOCK_KEYS_DEFAULT = 4;

  typedef logic [KEY_W-1:0] key_t;
  typedef logic [$clog2(MAX_LOCK_KEYS_DEFAULT)-1:0] slot_t;
  typedef key_t key_array_t [MAX_LOCK_KEYS_DEFAULT];

  // Outcome of evaluating one lock request against the table.
  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_ACK  = 2'd1,
    RESP_NACK = 2'd2
  } lock_resp_e;

  // Population count over up to 32 occupancy bits.
  function automatic int count_ones(input logic [31:0] bits);
    int n;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (bits[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/key_lock_table_lowest_set_enc.sv
// Priority encoder: index of the lowest set bit plus a found flag.
module lowest_set_enc #(
  parameter int W = 4,
  localparam int IW = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]  bits,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Scan from the top down so the last hit left standing is the lowest index.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      if (bits[i]) begin
        idx   = IW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_lock_table.sv
// Table of keys held locked by the update datapath, exported to the key snooper.
// Grants/refuses locks, releases on unlock or on age timeout.
module key_lock_table
  import lock_pkg::*;
#(
  parameter int   MAX_LOCK_KEYS  = MAX_LOCK_KEYS_DEFAULT,
  parameter key_t INVALID_KEY    = INVALID_KEY_DEFAULT,
  parameter int   TIMEOUT_CYCLES = 1024,
  localparam int  SW = $clog2(MAX_LOCK_KEYS),
  localparam int  CW = $clog2(MAX_LOCK_KEYS + 1),
  localparam int  AW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     lock_req,
  input  key_t                     lock_key,
  output logic                     lock_ack,
  output logic                     lock_nack,
  output logic [SW-1:0]            lock_slot,
  input  logic                     unlock_req,
  input  logic [SW-1:0]            unlock_slot,
  output logic                     unlock_err,
  output key_t                     locked_key [MAX_LOCK_KEYS],
  output logic [MAX_LOCK_KEYS-1:0] locked_valid,
  output logic [CW-1:0]            lock_count,
  output logic                     full,
  output logic                     timeout_err,
  output logic [SW-1:0]            timeout_slot
);

  logic [MAX_LOCK_KEYS-1:0] valid_q;
  key_t                     key_q [MAX_LOCK_KEYS];
  logic [AW-1:0]            age_q [MAX_LOCK_KEYS];

  logic [MAX_LOCK_KEYS-1:0] key_hit;
  logic [MAX_LOCK_KEYS-1:0] unlock_vec;
  logic [MAX_LOCK_KEYS-1:0] expired;
  logic                     unlock_hit;
  lock_resp_e               lock_resp;

  logic [SW-1:0] free_idx;
  logic          free_found;
  logic [SW-1:0] to_idx;
  logic          to_found;

  // Lowest free slot is where a granted key lands.
  lowest_set_enc #(.W(MAX_LOCK_KEYS)) u_free_enc (
    .bits  (~valid_q),
    .idx   (free_idx),
    .found (free_found)
  );

  // Lowest expired slot is the one reported and released this cycle.
  lowest_set_enc #(.W(MAX_LOCK_KEYS)) u_timeout_enc (
    .bits  (expired),
    .idx   (to_idx),
    .found (to_found)
  );

  // Decode requests against the table as it stands at the start of the cycle.
  always_comb begin
    key_hit    = '0;
    unlock_vec = '0;
    expired    = '0;
    for (int i = 0; i < MAX_LOCK_KEYS; i++) begin
      key_hit[i]    = valid_q[i] && (key_q[i] == lock_key);
      unlock_vec[i] = unlock_req && (unlock_slot == SW'(i));
      expired[i]    = valid_q[i] && !unlock_vec[i] &&
                      (age_q[i] >= AW'(TIMEOUT_CYCLES - 1));
    end
    unlock_hit = |(unlock_vec & valid_q);
    if (!lock_req) begin
      lock_resp = RESP_NONE;
    end else if (!free_found || (lock_key == INVALID_KEY) || (|key_hit)) begin
      lock_resp = RESP_NACK;
    end else begin
      lock_resp = RESP_ACK;
    end
  end

  // Table update and registered response pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= '0;
      lock_ack     <= 1'b0;
      lock_nack    <= 1'b0;
      lock_slot    <= '0;
      unlock_err   <= 1'b0;
      timeout_err  <= 1'b0;
      timeout_slot <= '0;
      for (int i = 0; i < MAX_LOCK_KEYS; i++) begin
        key_q[i] <= INVALID_KEY;
        age_q[i] <= '0;
      end
    end else begin
      lock_ack     <= (lock_resp == RESP_ACK);
      lock_nack    <= (lock_resp == RESP_NACK);
      lock_slot    <= (lock_resp == RESP_ACK) ? free_idx : '0;
      unlock_err   <= unlock_req && !unlock_hit;
      timeout_err  <= to_found;
      timeout_slot <= to_found ? to_idx : '0;
      for (int i = 0; i < MAX_LOCK_KEYS; i++) begin
        if (valid_q[i]) begin
          if (unlock_vec[i] || (to_found && (to_idx == SW'(i)))) begin
            valid_q[i] <= 1'b0;
          end else if (age_q[i] != AW'(TIMEOUT_CYCLES)) begin
            age_q[i] <= age_q[i] + AW'(1);
          end
        end else if ((lock_resp == RESP_ACK) && (free_idx == SW'(i))) begin
          valid_q[i] <= 1'b1;
          key_q[i]   <= lock_key;
          age_q[i]   <= '0;
        end
      end
    end
  end

  // Free slots always show the sentinel so the snooper cannot match them.
  always_comb begin
    for (int i = 0; i < MAX_LOCK_KEYS; i++) begin
      locked_key[i] = valid_q[i] ? key_q[i] : INVALID_KEY;
    end
  end

  assign locked_valid = valid_q;
  assign full         = &valid_q;
  assign lock_count   = CW'(count_ones(32'(valid_q)));

endmodule

// File: tb/tb_key_lock_table.sv
// Scoreboard testbench for key_lock_table: directed test-plan sequences plus
// randomized traffic, checked against a deadline-based reference model.
module tb_key_lock_table;
  import lock_pkg::*;

  localparam int   N   = 4;
  localparam int   T   = 8;
  localparam key_t INV = INVALID_KEY_DEFAULT;

  logic  clk = 1'b0;
  logic  reset = 1'b1;
  logic  lock_req = 1'b0;
  logic  unlock_req = 1'b0;
  key_t  lock_key = '0;
  slot_t unlock_slot = '0;

  logic         lock_ack, lock_nack, unlock_err, full, timeout_err;
  slot_t        lock_slot, timeout_slot;
  key_t         locked_key [N];
  logic [N-1:0] locked_valid;
  logic [2:0]   lock_count;

  key_lock_table #(
    .MAX_LOCK_KEYS (N),
    .INVALID_KEY   (INV),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .lock_req     (lock_req),
    .lock_key     (lock_key),
    .lock_ack     (lock_ack),
    .lock_nack    (lock_nack),
    .lock_slot    (lock_slot),
    .unlock_req   (unlock_req),
    .unlock_slot  (unlock_slot),
    .unlock_err   (unlock_err),
    .locked_key   (locked_key),
    .locked_valid (locked_valid),
    .lock_count   (lock_count),
    .full         (full),
    .timeout_err  (timeout_err),
    .timeout_slot (timeout_slot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                   ack, nack, uerr, terr, full;
    slot_t                  slot, tslot;
    logic [N-1:0][KEY_W-1:0] keys;
    logic [N-1:0]           vld;
    logic [2:0]             cnt;
  } exp_t;

  exp_t exp_q [$];
  int compared = 0;
  int mismatched = 0;

  // Reference model: a free slot holds INV; each held key remembers the
  // cycle it was granted, and becomes due for forced release T cycles later.
  key_array_t m_key;
  int         m_grant [N];
  int         cyc = 0;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic lr, input key_t lk,
                            input logic ur, input slot_t us);
    exp_t e;
    int   n, free, to;
    bit   dup, unlock_ok;
    e.ack = 0; e.nack = 0; e.uerr = 0; e.terr = 0;
    e.slot = '0; e.tslot = '0;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_key[i] = INV;
        m_grant[i] = 0;
      end
    end else begin
      n = 0; free = -1; dup = 0;
      for (int i = 0; i < N; i++) begin
        if (m_key[i] != INV) begin
          n++;
          if (m_key[i] == lk) dup = 1;
        end else if (free < 0) begin
          free = i;
        end
      end
      e.ack  = lr && (n < N) && (lk != INV) && !dup;
      e.nack = lr && !e.ack;
      if (e.ack) e.slot = slot_t'(free);
      unlock_ok = ur && (m_key[us] != INV);
      e.uerr = ur && !unlock_ok;
      to = -1;
      for (int i = 0; i < N; i++) begin
        if (to < 0 && m_key[i] != INV && cyc >= m_grant[i] + T && !(ur && int'(us) == i))
          to = i;
      end
      if (unlock_ok) m_key[us] = INV;
      if (to >= 0) begin
        m_key[to] = INV;
        e.terr = 1;
        e.tslot = slot_t'(to);
      end
      if (e.ack) begin
        m_key[free] = lk;
        m_grant[free] = cyc;
      end
    end
    n = 0;
    for (int i = 0; i < N; i++) begin
      e.keys[i] = m_key[i];
      e.vld[i] = (m_key[i] != INV);
      if (e.vld[i]) n++;
    end
    e.cnt = 3'(n);
    e.full = (n == N);
    exp_q.push_back(e);
    cyc++;
  endtask

  // One call drives one clock cycle of inputs and records what must follow.
  task automatic apply_stimulus(input logic rst, input logic lr, input key_t lk,
                                input logic ur, input slot_t us);
    @(negedge clk);
    reset = rst; lock_req = lr; lock_key = lk; unlock_req = ur; unlock_slot = us;
    model_step(rst, lr, lk, ur, us);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 1'b0, '0, 1'b0, '0);
  endtask

  // Monitor: after each edge, pop the expected response and compare.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("lock_ack", 32'(lock_ack), 32'(e.ack));
        check_output("lock_nack", 32'(lock_nack), 32'(e.nack));
        if (e.ack) check_output("lock_slot", 32'(lock_slot), 32'(e.slot));
        check_output("unlock_err", 32'(unlock_err), 32'(e.uerr));
        check_output("timeout_err", 32'(timeout_err), 32'(e.terr));
        if (e.terr) check_output("timeout_slot", 32'(timeout_slot), 32'(e.tslot));
        check_output("locked_valid", 32'(locked_valid), 32'(e.vld));
        check_output("lock_count", 32'(lock_count), 32'(e.cnt));
        check_output("full", 32'(full), 32'(e.full));
        for (int i = 0; i < N; i++)
          check_output($sformatf("locked_key[%0d]", i), locked_key[i], e.keys[i]);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int r;
    key_t lk;
    $display("[TB] starting key_lock_table bench");
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0);
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0);
    // Fill the table, then overflow, unlock/lock interplay and unlock errors.
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'h20, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'h30, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'h40, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'h50, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'h99, 1'b1, 2'd1);
    apply_stimulus(1'b0, 1'b1, 32'h99, 1'b0, '0);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 2'd1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 2'd1);
    idle(12);
    // Duplicate back-to-back and sentinel key.
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'h10, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, INV, 1'b0, '0);
    idle(2);
    // Plain timeout, then unlock exactly on the timeout cycle.
    apply_stimulus(1'b1, 1'b0, '0, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'hA, 1'b0, '0);
    idle(T + 2);
    apply_stimulus(1'b0, 1'b1, 32'hB, 1'b0, '0);
    idle(T - 1);
    apply_stimulus(1'b0, 1'b0, '0, 1'b1, 2'd0);
    idle(3);
    // Two slots timing out on consecutive cycles.
    apply_stimulus(1'b0, 1'b1, 32'h100, 1'b0, '0);
    apply_stimulus(1'b0, 1'b1, 32'h200, 1'b0, '0);
    idle(T + 2);
    // Reset in the middle of activity drops the concurrent requests.
    apply_stimulus(1'b0, 1'b1, 32'h300, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, 32'h400, 1'b1, 2'd0);
    idle(2);
    // Randomized traffic over a small key pool to provoke duplicates.
    for (int k = 0; k < 500; k++) begin
      r = $urandom_range(0, 15);
      lk = (r == 15) ? INV : key_t'((r % 6) + 1);
      apply_stimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 1) == 1), lk,
                     ($urandom_range(0, 2) == 0), slot_t'($urandom_range(0, N - 1)));
    end
    idle(3);
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    #2;
    if (exp_q.size() > 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain: %0d expected responses left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/key_lock_table.md
# key_lock_table

Holds the set of keys currently locked by the accumulate/update datapath and presents them as a flat array to the downstream key snooper, which flags conflicts on incoming adds. It grants or refuses lock requests, releases locks on explicit unlock or watchdog timeout, and drives unused slots with a sentinel key so the snooper never matches them. It sits between the update issue logic (lock/unlock requester) and the snooper (consumer of `locked_key`).

## Interface
- `MAX_LOCK_KEYS`, 4: number of lock slots, ≥2.
- `INVALID_KEY`, 32'hFFFF_FFFF: sentinel driven on free slots; never a legal key.
- `TIMEOUT_CYCLES`, 1024: cycles a slot may stay locked before forced release; width of age counters is `$clog2(TIMEOUT_CYCLES+1)`.

- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `lock_req` in 1: single-cycle lock request strobe.
- `lock_key` in 32: key to lock, sampled with `lock_req`.
- `lock_ack` out 1: one-cycle pulse, lock granted.
- `lock_nack` out 1: one-cycle pulse, lock refused.
- `lock_slot` out SW=`$clog2(MAX_LOCK_KEYS)`: granted slot index, valid with `lock_ack`.
- `unlock_req` in 1: single-cycle release strobe.
- `unlock_slot` in SW: slot to release.
- `unlock_err` out 1: one-cycle pulse, unlock of a free slot.
- `locked_key` out 32 × MAX_LOCK_KEYS (unpacked array): per-slot key or `INVALID_KEY`.
- `locked_valid` out MAX_LOCK_KEYS: per-slot occupied bit.
- `lock_count` out `$clog2(MAX_LOCK_KEYS+1)`: occupied slots.
- `full` out 1: all slots occupied.
- `timeout_err` out 1: one-cycle pulse, a slot was force-released.
- `timeout_slot` out SW: slot force-released, valid with `timeout_err`.

## Operation
- Reset: all slots free, `locked_key[i]=INVALID_KEY`, all other outputs 0, age counters 0.
- Lock evaluation uses table state at the start of the cycle (before any same-cycle unlock/timeout).
- Nack if: table full, `lock_key==INVALID_KEY`, or `lock_key` equals any valid slot key. Otherwise ack; allocate lowest-index free slot, write key, set valid, clear age.
- Exactly one of `lock_ack`/`lock_nack` per `lock_req`; never both.
- Unlock of a valid slot: clear valid, slot key returns to `INVALID_KEY`. Unlock of a free slot: no state change, `unlock_err` pulse.
- Age counter increments each cycle a slot is valid; on reaching `TIMEOUT_CYCLES` slot is freed, `timeout_err`/`timeout_slot` pulse. Multiple simultaneous timeouts: lowest index reported this cycle, others freed the following cycle(s) in index order (counter saturates at limit until reported).
- Unlock and timeout same slot same cycle: unlock wins, no `timeout_err`.
- Freed slot is allocatable from the next cycle, not the same cycle.
- `lock_count`, `full` reflect registered table state.

## Timing
- Lock response: `lock_req` at cycle N → ack/nack and `lock_slot` at N+1; `locked_key`/`locked_valid` updated at N+1.
- Back-to-back `lock_req` every cycle supported; request at N+1 sees the grant from N (duplicate key at N+1 → nack).
- Unlock at N → slot shows `INVALID_KEY` at N+1; `unlock_err` at N+1.
- Timeout: slot locked at N (visible N+1) is force-freed with `timeout_err` at N+1+TIMEOUT_CYCLES if no unlock.
- Reset asserted mid-operation clears everything next edge; pending responses dropped.

## Structure
- Package `lock_pkg`: `KEY_W=32`, `INVALID_KEY` default, `slot_t` typedef helper, key array typedef.
- Sub-module `lowest_set_enc`: parameterised priority encoder (lowest set bit + found flag), used for free-slot allocation and timeout reporting.

## Test plan
- Reset, then lock 0x10,0x20,0x30,0x40 on consecutive cycles → acks with slots 0,1,2,3; `full=1`, `lock_count=4`.
- Fifth lock 0x50 while full → `lock_nack` at N+1; table unchanged.
- Lock 0x10 twice back-to-back → ack slot 0, then nack; lock `INVALID_KEY` → nack.
- Unlock slot 1 and lock 0x99 same cycle with table full → nack; lock 0x99 next cycle → ack slot 1; unlock free slot 1 twice → second gives `unlock_err`.
- TIMEOUT_CYCLES=8: lock 0xA at N → `timeout_err`, `timeout_slot=0` at N+9, `locked_key[0]=INVALID_KEY`; repeat with unlock at the timeout cycle → no `timeout_err`.
- Two slots locked same age reaching timeout → `timeout_err` slot 0 then slot 1 on consecutive cycles.
